// File: rtl/gcn_comb_pkg.sv
// Shared definitions for the combination result read path.
//   row_data_t  : one row of products as stored in the result buffer
//   rd_state_e  : read sequencer states
//   SKID_DEPTH  : entries in the output skid FIFO (credit limit for reads)
package gcn_comb_pkg;

  localparam int PKG_WEIGHT_COLS    = 3;
  localparam int PKG_DOT_PROD_WIDTH = 16;
  localparam int SKID_DEPTH         = 2;

  typedef logic [PKG_WEIGHT_COLS*PKG_DOT_PROD_WIDTH-1:0] row_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/row_skid_fifo.sv
// Two-entry skid FIFO holding {row tag, row data}. The head entry is a
// register, so the output is never a combinational path from the push side.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push, push_tag/data   write an entry (must not be issued when full)
//   pop                   remove the head entry (only when not empty)
//   head_tag, head_data   registered head entry
//   full, empty, count    occupancy status
module row_skid_fifo
  import gcn_comb_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 48,
  parameter int CNT_W  = $clog2(SKID_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);

  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] push_ent;

  assign push_ent = {push_tag, push_data};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      CNT_ZERO: begin
        if (push) begin
          head_d  = push_ent;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        // push+pop with one entry: the new entry goes straight to the head
        if (push && pop) begin
          head_d = push_ent;
        end else if (push) begin
          tail_d  = push_ent;
          count_d = CNT_FULL;
        end else if (pop) begin
          count_d = CNT_ZERO;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = CNT_ONE;
          if (push) begin
            tail_d  = push_ent;
            count_d = CNT_FULL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_tag  = head_q[ENT_W-1:DATA_W];
  assign head_data = head_q[DATA_W-1:0];
  assign count     = count_q;
  assign empty     = (count_q == CNT_ZERO);
  assign full      = (count_q == CNT_FULL);

  // The upstream credit logic must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/combination_row_reader.sv
// Read-side sequencer for the combination result buffer. On start it walks
// row addresses 0..FEATURE_ROWS-1, issues synchronous reads, and streams each
// row with its index downstream over valid/ready through a 2-entry skid FIFO.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 1-cycle request, sampled only in IDLE
//   rd_en, rd_addr        result buffer read strobe and row address
//   rd_data               row data, valid one cycle after rd_en
//   out_valid, out_ready  downstream handshake
//   out_data, out_row     row payload and its row index
//   busy                  high in READ/DRAIN/DONE
//   done                  1-cycle pulse after the final row is accepted
module combination_row_reader
  import gcn_comb_pkg::*;
#(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = PKG_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH = PKG_DOT_PROD_WIDTH,
  parameter int FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  rd_en,
  output logic [FEATURE_WIDTH-1:0]              rd_addr,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] rd_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] out_data,
  output logic [FEATURE_WIDTH-1:0]              out_row,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ROW_W = WEIGHT_COLS * DOT_PROD_WIDTH;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);

  rd_state_e                state_q, state_d;
  logic [FEATURE_WIDTH-1:0] row_q, row_d;
  logic                     inflight_q;
  logic [FEATURE_WIDTH-1:0] inflight_row_q;

  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W:0]           credit_used;
  logic [CNT_W:0]           credit_lim;
  logic                     last_issued;
  logic                     drain_clear;

  assign pop = out_valid && out_ready;

  // A read is allowed only if, after this cycle's pop, the row it returns
  // still has a FIFO slot: buffered + in flight - popped < SKID_DEPTH.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_lim  = (CNT_W+1)'(SKID_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign rd_en       = (state_q == READ) && (credit_used < credit_lim);
  assign rd_addr     = row_q;
  assign last_issued = rd_en && (row_q == LAST_ROW);

  // Nothing in flight and the FIFO empties by the end of this cycle, so the
  // final handshake is happening now (or already happened).
  assign drain_clear = !inflight_q && (fifo_empty || (fifo_count == CNT_ONE && pop));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = READ;
      READ:    if (last_issued) state_d = DRAIN;
      DRAIN:   if (drain_clear) state_d = DONE;
      default:                  state_d = IDLE;
    endcase
  end

  // Row counter saturates at the last row; it is rewound when the transfer ends.
  always_comb begin
    row_d = row_q;
    if (state_q == DONE) begin
      row_d = '0;
    end else if (rd_en && (row_q != LAST_ROW)) begin
      row_d = row_q + FEATURE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_row_q <= '0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      inflight_q     <= rd_en;
      if (rd_en) begin
        inflight_row_q <= row_q;
      end
    end
  end

  // Read data arrives one cycle after rd_en and is pushed with its row tag.
  row_skid_fifo #(
    .TAG_W (FEATURE_WIDTH),
    .DATA_W(ROW_W),
    .CNT_W (CNT_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_tag (inflight_row_q),
    .push_data(rd_data),
    .pop      (pop),
    .head_tag (out_row),
    .head_data(out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_combination_row_reader.sv
module tb_combination_row_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [47:0] mem [8];

  // 6-row instance
  logic s0 = 0, r0 = 0, e0, v0, b0, d0;
  logic [2:0] a0, o0;
  logic [47:0] rd0, od0;
  // 1-row instance
  logic s1 = 0, r1 = 0, e1, v1, b1, d1;
  logic [0:0] a1, o1;
  logic [47:0] rd1, od1;
  // 8-row instance
  logic s8 = 0, r8 = 0, e8, v8, b8, d8;
  logic [2:0] a8, o8;
  logic [47:0] rd8, od8;

  combination_row_reader #(.FEATURE_ROWS(6)) dut (
    .clk(clk), .reset(reset), .start(s0), .rd_en(e0), .rd_addr(a0), .rd_data(rd0),
    .out_valid(v0), .out_ready(r0), .out_data(od0), .out_row(o0), .busy(b0), .done(d0));
  combination_row_reader #(.FEATURE_ROWS(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .rd_en(e1), .rd_addr(a1), .rd_data(rd1),
    .out_valid(v1), .out_ready(r1), .out_data(od1), .out_row(o1), .busy(b1), .done(d1));
  combination_row_reader #(.FEATURE_ROWS(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .rd_en(e8), .rd_addr(a8), .rd_data(rd8),
    .out_valid(v8), .out_ready(r8), .out_data(od8), .out_row(o8), .busy(b8), .done(d8));

  // Result buffer: synchronous read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (e0) rd0 <= mem[a0];
    if (e1) rd1 <= mem[{2'b00, a1}];
    if (e8) rd8 <= mem[a8];
  end

  int checks = 0;
  int errors = 0;

  // Observations gathered from one transfer
  int rd_cyc[$];
  int rd_adr[$];
  int acc_row[$];
  int acc_cyc[$];
  logic [47:0] acc_dat[$];
  int done_n, done_cyc, busy_fall, unstable, max_out, addr_wrap;

  task automatic fill_random();
    logic [63:0] t;
    for (int i = 0; i < 8; i++) begin
      t = {$urandom(), $urandom()};
      mem[i] = t[47:0];
    end
  endtask

  // Drive one transfer on instance sel (0:6 rows, 1:1 row, 2:8 rows).
  // mode 0: ready always high; 1: ready low in cycles 3..7; 2: random ready.
  task automatic collect(input int sel, input int mode, input int second_start, input int budget);
    int n, issued, accepted, prev_row, adr, row;
    bit prev_stall;
    logic [47:0] prev_dat, dat;
    logic en, vld, bsy, dn, rdy, st;
    n = (sel == 0) ? 6 : (sel == 1) ? 1 : 8;
    rd_cyc.delete(); rd_adr.delete(); acc_row.delete(); acc_cyc.delete(); acc_dat.delete();
    done_n = 0; done_cyc = -1; busy_fall = -1; unstable = 0; max_out = 0; addr_wrap = 0;
    issued = 0; accepted = 0; prev_stall = 0; prev_row = 0; prev_dat = '0;
    for (int c = 0; c < budget; c++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 3 && c <= 7) : 1'($urandom_range(0, 1));
      st  = (c == 0) || (c == second_start);
      case (sel)
        0: begin s0 = st; r0 = rdy; end
        1: begin s1 = st; r1 = rdy; end
        default: begin s8 = st; r8 = rdy; end
      endcase
      @(negedge clk);
      case (sel)
        0: begin en = e0; adr = int'(a0); vld = v0; row = int'(o0); dat = od0; bsy = b0; dn = d0; end
        1: begin en = e1; adr = int'(a1); vld = v1; row = int'(o1); dat = od1; bsy = b1; dn = d1; end
        default: begin en = e8; adr = int'(a8); vld = v8; row = int'(o8); dat = od8; bsy = b8; dn = d8; end
      endcase
      if (en) begin rd_cyc.push_back(c); rd_adr.push_back(adr); issued++; end
      if (issued == n && !en && bsy && adr != n - 1) addr_wrap++;
      if (prev_stall && (!vld || row != prev_row || dat != prev_dat)) unstable++;
      if (vld && rdy) begin
        acc_row.push_back(row); acc_dat.push_back(dat); acc_cyc.push_back(c); accepted++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      prev_stall = vld && !rdy; prev_row = row; prev_dat = dat;
      if (dn) begin done_n++; done_cyc = c; end
      if (done_n > 0 && !bsy && busy_fall < 0) busy_fall = c;
      @(posedge clk); #1;
      if (busy_fall >= 0 && c >= busy_fall + 3) break;
    end
    s0 = 0; r0 = 0; s1 = 0; r1 = 0; s8 = 0; r8 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({e0, a0, v0, od0, o0, b0, d0} !== '0) begin
      errors++; $display("FAIL reset_outputs_6: got %h required 0", {e0, a0, v0, od0, o0, b0, d0});
    end
    checks++;
    if ({e1, a1, v1, od1, o1, b1, d1, e8, a8, v8, od8, o8, b8, d8} !== '0) begin
      errors++; $display("FAIL reset_outputs_edge: got nonzero outputs on 1-row or 8-row instance");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    fill_random();
    collect(0, 0, -1, 60);
    checks++;
    if (rd_cyc.size() != 6) begin
      errors++; $display("FAIL stream_rd_count: got %0d required 6", rd_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rd_cyc[i] != i + 1 || rd_adr[i] != i) begin
          errors++; $display("FAIL stream_rd[%0d]: got cycle %0d addr %0d required cycle %0d addr %0d",
                             i, rd_cyc[i], rd_adr[i], i + 1, i);
        end
      end
    end
    checks++;
    if (acc_row.size() != 6) begin
      errors++; $display("FAIL stream_out_count: got %0d required 6", acc_row.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_row[i] != i || acc_cyc[i] != i + 3 || acc_dat[i] !== mem[i]) begin
          errors++; $display("FAIL stream_out[%0d]: got row %0d cycle %0d data %h required row %0d cycle %0d data %h",
                             i, acc_row[i], acc_cyc[i], acc_dat[i], i, i + 3, mem[i]);
        end
      end
    end
    checks++;
    if (done_n != 1 || done_cyc != 9) begin
      errors++; $display("FAIL stream_done: got %0d pulses at cycle %0d required 1 at cycle 9", done_n, done_cyc);
    end
    checks++;
    if (busy_fall != 10) begin
      errors++; $display("FAIL stream_busy_fall: got cycle %0d required 10", busy_fall);
    end
  endtask

  task automatic test_backpressure();
    int early;
    for (int i = 0; i < 8; i++) mem[i] = 48'(i * 'h11);
    collect(0, 1, -1, 80);
    early = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= 3 && rd_cyc[i] <= 7) early++;
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL bp_rd_during_stall: got %0d reads required 0", early);
    end
    checks++;
    if (max_out != 2) begin
      errors++; $display("FAIL bp_outstanding: got %0d required 2", max_out);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL bp_stable: got %0d changes while stalled required 0", unstable);
    end
    checks++;
    if (acc_row.size() != 6) begin
      errors++; $display("FAIL bp_out_count: got %0d required 6", acc_row.size());
    end else begin
      checks++;
      if (acc_cyc[0] != 8) begin
        errors++; $display("FAIL bp_first_accept: got cycle %0d required 8", acc_cyc[0]);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (acc_row[i] != i || acc_dat[i] !== 48'(i * 'h11)) begin
          errors++; $display("FAIL bp_out[%0d]: got row %0d data %h required row %0d data %h",
                             i, acc_row[i], acc_dat[i], i, 48'(i * 'h11));
        end
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++; $display("FAIL bp_done: got %0d pulses required 1", done_n);
    end
  endtask

  task automatic test_random_ready();
    int bad;
    for (int t = 0; t < 20; t++) begin
      fill_random();
      collect(0, 2, -1, 300);
      bad = 0;
      if (acc_row.size() != 6) bad++;
      else for (int i = 0; i < 6; i++) if (acc_row[i] != i || acc_dat[i] !== mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand_order[%0d]: got %0d rows with %0d wrong required rows 0..5", t, acc_row.size(), bad);
      end
      checks++;
      if (done_n != 1 || acc_cyc.size() == 0 || done_cyc != acc_cyc[$] + 1) begin
        errors++; $display("FAIL rand_done[%0d]: got %0d pulses at cycle %0d required 1 after last accept", t, done_n, done_cyc);
      end
      checks++;
      if (unstable != 0 || max_out > 2) begin
        errors++; $display("FAIL rand_handshake[%0d]: got %0d unstable, %0d outstanding required 0 and <=2", t, unstable, max_out);
      end
    end
  endtask

  task automatic test_start_busy();
    fill_random();
    collect(0, 0, 4, 60);
    checks++;
    if (acc_row.size() != 6 || rd_cyc.size() != 6) begin
      errors++; $display("FAIL busy_start_rows: got %0d out %0d reads required 6", acc_row.size(), rd_cyc.size());
    end
    checks++;
    if (done_n != 1 || done_cyc != 9) begin
      errors++; $display("FAIL busy_start_done: got %0d pulses at cycle %0d required 1 at 9", done_n, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int hs, stray, bad;
    fill_random();
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      s0 = (c == 0); r0 = 1'b1;
      @(negedge clk);
      if (v0 && r0) hs++;
      @(posedge clk); #1;
    end
    s0 = 0;
    checks++;
    if (hs != 2) begin
      errors++; $display("FAIL rst_mid_handshakes: got %0d required 2", hs);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({e0, a0, v0, od0, o0, b0, d0} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h required 0", {e0, a0, v0, od0, o0, b0, d0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (v0 || d0 || b0 || e0) stray++;
      @(posedge clk); #1;
    end
    r0 = 0;
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", stray);
    end
    collect(0, 0, -1, 60);
    bad = 0;
    if (acc_row.size() != 6) bad++;
    else for (int i = 0; i < 6; i++) if (acc_row[i] != i || acc_dat[i] !== mem[i] || acc_cyc[i] != i + 3) bad++;
    checks++;
    if (bad != 0 || done_n != 1 || done_cyc != 9) begin
      errors++; $display("FAIL rst_mid_restart: got %0d rows, %0d bad, %0d done at %0d required 6 rows from 0, done at 9",
                         acc_row.size(), bad, done_n, done_cyc);
    end
  endtask

  task automatic test_edge_rows();
    int bad;
    fill_random();
    collect(1, 0, -1, 40);
    checks++;
    if (rd_cyc.size() != 1 || (rd_adr.size() > 0 && rd_adr[0] != 0)) begin
      errors++; $display("FAIL one_row_reads: got %0d reads required 1 at addr 0", rd_cyc.size());
    end
    checks++;
    if (acc_row.size() != 1 || (acc_row.size() > 0 && (acc_row[0] != 0 || acc_dat[0] !== mem[0]))) begin
      errors++; $display("FAIL one_row_out: got %0d rows required 1 (row 0)", acc_row.size());
    end
    checks++;
    if (done_n != 1 || acc_cyc.size() == 0 || done_cyc != acc_cyc[$] + 1) begin
      errors++; $display("FAIL one_row_done: got %0d pulses at cycle %0d required 1 after accept", done_n, done_cyc);
    end

    fill_random();
    collect(2, 2, -1, 400);
    bad = 0;
    if (rd_adr.size() != 8) bad++;
    else for (int i = 0; i < 8; i++) if (rd_adr[i] != i) bad++;
    checks++;
    if (bad != 0 || addr_wrap != 0) begin
      errors++; $display("FAIL eight_row_addr: got %0d reads, %0d bad, %0d wraps required 0..7 and no wrap",
                         rd_adr.size(), bad, addr_wrap);
    end
    bad = 0;
    if (acc_row.size() != 8) bad++;
    else for (int i = 0; i < 8; i++) if (acc_row[i] != i || acc_dat[i] !== mem[i]) bad++;
    checks++;
    if (bad != 0 || done_n != 1) begin
      errors++; $display("FAIL eight_row_out: got %0d rows, %0d bad, %0d done required 8 rows, 1 done",
                         acc_row.size(), bad, done_n);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_start_busy();
    test_reset_mid();
    test_edge_rows();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
